// File: rtl/dyser_send_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dyser_send_queue_if                                                      |
// | Core-side enqueue lanes and dual-lane DySER send lanes, bundled.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dyser_send_queue_if #(
  parameter int DATA_WIDTH = 63
) ();
  logic                  enq_en0;
  logic [2:0]            enq_port0;
  logic [DATA_WIDTH:0]   enq_data0;
  logic                  enq_en1;
  logic [2:0]            enq_port1;
  logic [DATA_WIDTH:0]   enq_data1;
  logic                  enq_stall;
  logic                  send_stall;
  logic [DATA_WIDTH:0]   send_data_r0;
  logic [2:0]            send_port_r0;
  logic                  send_en0;
  logic [DATA_WIDTH:0]   send_data_r1;
  logic [2:0]            send_port_r1;
  logic                  send_en1;

  // Queue side
  modport slave (
    input  enq_en0, enq_port0, enq_data0, enq_en1, enq_port1, enq_data1, send_stall,
    output enq_stall, send_data_r0, send_port_r0, send_en0,
           send_data_r1, send_port_r1, send_en1
  );

  // Core / fabric side
  modport master (
    output enq_en0, enq_port0, enq_data0, enq_en1, enq_port1, enq_data1, send_stall,
    input  enq_stall, send_data_r0, send_port_r0, send_en0,
           send_data_r1, send_port_r1, send_en1
  );
endinterface
`default_nettype wire

// File: rtl/dyser_send_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dyser_send_queue                                                         |
// | In-order circular send buffer draining up to two beats/cycle into dyser. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dyser_send_queue #(
  parameter int DATA_WIDTH = 63,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  wire              clk,
  input  wire              rst,
  dyser_send_queue_if.slave q,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_TWO   = (PTR_W+1)'(2);

  logic [2:0]          r_port [DEPTH];
  logic [DATA_WIDTH:0] r_data [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W:0]      r_count;

  logic [PTR_W-1:0]    w_head1;
  logic [PTR_W-1:0]    w_tail1;
  logic [PTR_W:0]      w_free;
  logic [PTR_W:0]      w_enq_cnt;
  logic [PTR_W:0]      w_deq_cnt;
  logic                w_stall;
  logic                w_wr0;
  logic                w_wr1;
  logic                w_en0;
  logic                w_en1;
  logic                w_rd0;
  logic                w_rd1;

  // Stall looks only at registered count: two free slots guarantee a pair fits.
  always_comb begin
    w_free    = c_DEPTH - r_count;
    w_stall   = w_free < c_TWO;
    w_wr0     = q.enq_en0 & ~w_stall;
    w_wr1     = q.enq_en1 & ~w_stall;
    w_tail1   = r_tail + PTR_W'(w_wr0);
    w_head1   = r_head + PTR_W'(1);
    w_en0     = (r_count != '0);
    w_en1     = (r_count >= c_TWO) && (r_port[w_head1] != r_port[r_head]);
    w_rd0     = w_en0 & ~q.send_stall;
    w_rd1     = w_en1 & ~q.send_stall;
    w_enq_cnt = (PTR_W+1)'(w_wr0) + (PTR_W+1)'(w_wr1);
    w_deq_cnt = (PTR_W+1)'(w_rd0) + (PTR_W+1)'(w_rd1);
  end

  always_ff @(posedge clk) begin
    if (w_wr0) begin
      r_port[r_tail] <= q.enq_port0;
      r_data[r_tail] <= q.enq_data0;
    end
    if (w_wr1) begin
      r_port[w_tail1] <= q.enq_port1;
      r_data[w_tail1] <= q.enq_data1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_cnt);
      r_tail  <= r_tail + PTR_W'(w_enq_cnt);
      r_count <= r_count + w_enq_cnt - w_deq_cnt;
    end
  end

  // Disabled lanes drive zeros so stale storage never leaks to the fabric.
  assign q.enq_stall    = w_stall;
  assign q.send_en0     = w_en0;
  assign q.send_port_r0 = w_en0 ? r_port[r_head]  : 3'd0;
  assign q.send_data_r0 = w_en0 ? r_data[r_head]  : '0;
  assign q.send_en1     = w_en1;
  assign q.send_port_r1 = w_en1 ? r_port[w_head1] : 3'd0;
  assign q.send_data_r1 = w_en1 ? r_data[w_head1] : '0;
  assign occupancy      = r_count;

endmodule
`default_nettype wire
